fnd_scan_counter: RTL and testbench

FND_SCAN_COUNTER -- requirements
Module: fnd_scan_counter

---
 rtl/fnd_scan_counter.sv | 121 ++++++++++++
 tb/tb_fnd_scan_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_counter.sv
// Four-digit BCD up-counter with a multiplexed FND scan driver.
// The tick prescaler paces counting; a free-running scan prescaler rotates the digit select.
module fnd_scan_counter #(
  parameter int P_TICK_DIV = 10_000_000,
  parameter int P_SCAN_DIV = 100_000,
  parameter int P_BLANK    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic        i_clear,
  output logic [15:0] o_count,
  output logic [3:0]  o_bcdData,
  output logic [3:0]  o_digitSel,
  output logic        o_carry
);

  localparam int TickW = $clog2(P_TICK_DIV);
  localparam int ScanW = $clog2(P_SCAN_DIV);

  logic [TickW-1:0] tickCnt;
  logic [ScanW-1:0] scanCnt;
  logic [1:0]       scanIdx;
  logic [15:0]      countReg;
  logic [15:0]      countNext;
  logic             carryReg;
  logic             tick;
  logic             scanTc;
  logic [3:0]       d0, d1, d2, d3;
  logic             nine0, nine1, nine2, nine3;
  logic [3:0]       rawDigit;
  logic             blankDigit;

  function automatic logic [3:0] incDigit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  assign d0 = countReg[3:0];
  assign d1 = countReg[7:4];
  assign d2 = countReg[11:8];
  assign d3 = countReg[15:12];

  assign nine0 = (d0 == 4'd9);
  assign nine1 = (d1 == 4'd9);
  assign nine2 = (d2 == 4'd9);
  assign nine3 = (d3 == 4'd9);

  assign tick   = i_run && (tickCnt == TickW'(P_TICK_DIV - 1));
  assign scanTc = (scanCnt == ScanW'(P_SCAN_DIV - 1));

  // Ripple the decimal carry upward only through digits sitting at 9.
  always_comb begin
    countNext = {d3, d2, d1, incDigit(d0)};
    if (nine0)                 countNext[7:4]   = incDigit(d1);
    if (nine0 && nine1)        countNext[11:8]  = incDigit(d2);
    if (nine0 && nine1 && nine2) countNext[15:12] = incDigit(d3);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tickCnt  <= '0;
      countReg <= '0;
      carryReg <= 1'b0;
    end else if (i_clear) begin
      tickCnt  <= '0;
      countReg <= '0;
      carryReg <= 1'b0;
    end else begin
      carryReg <= tick && nine0 && nine1 && nine2 && nine3;
      if (tick) begin
        tickCnt  <= '0;
        countReg <= countNext;
      end else if (i_run) begin
        tickCnt <= tickCnt + TickW'(1);
      end
    end
  end

  // Scan keeps running through clear and pause so the display never freezes on one digit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      scanCnt <= '0;
      scanIdx <= 2'd0;
    end else if (scanTc) begin
      scanCnt <= '0;
      scanIdx <= scanIdx + 2'd1;
    end else begin
      scanCnt <= scanCnt + ScanW'(1);
    end
  end

  always_comb begin
    rawDigit   = d0;
    blankDigit = 1'b0;
    case (scanIdx)
      2'd0: begin
        rawDigit   = d0;
        blankDigit = 1'b0;
      end
      2'd1: begin
        rawDigit   = d1;
        blankDigit = (d1 == 4'd0) && (d2 == 4'd0) && (d3 == 4'd0);
      end
      2'd2: begin
        rawDigit   = d2;
        blankDigit = (d2 == 4'd0) && (d3 == 4'd0);
      end
      default: begin
        rawDigit   = d3;
        blankDigit = (d3 == 4'd0);
      end
    endcase
  end

  // 4'hF tells the downstream decoder to turn every segment off.
  assign o_bcdData  = ((P_BLANK != 0) && blankDigit) ? 4'hF : rawDigit;
  assign o_digitSel = ~(4'b0001 << scanIdx);
  assign o_count    = countReg;
  assign o_carry    = carryReg;

endmodule

// File: tb/tb_fnd_scan_counter.sv
// Bench for fnd_scan_counter: a decimal-arithmetic model checked every cycle,
// plus literal expectations for reset, increment, wrap, blanking, clear and async reset.
module tb_fnd_scan_counter;

  localparam int TICK = 4;
  localparam int SCAN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic clr = 1'b0;

  logic [15:0] countB, countR;
  logic [3:0]  bcdB, bcdR, selB, selR;
  logic        carryB, carryR;

  int passCnt  = 0;
  int totalCnt = 0;

  fnd_scan_counter #(.P_TICK_DIV(TICK), .P_SCAN_DIV(SCAN), .P_BLANK(1)) dutB (
    .i_clk(clk), .i_reset(rst), .i_run(run), .i_clear(clr),
    .o_count(countB), .o_bcdData(bcdB), .o_digitSel(selB), .o_carry(carryB)
  );

  fnd_scan_counter #(.P_TICK_DIV(TICK), .P_SCAN_DIV(SCAN), .P_BLANK(0)) dutR (
    .i_clk(clk), .i_reset(rst), .i_run(run), .i_clear(clr),
    .o_count(countR), .o_bcdData(bcdR), .o_digitSel(selR), .o_carry(carryR)
  );

  always #5 clk = ~clk;

  // Model state: count as a plain decimal integer, phases as integers.
  int mCount = 0;
  int mTick  = 0;
  int mScan  = 0;
  int mIdx   = 0;
  bit mCarry = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCount = 0; mTick = 0; mScan = 0; mIdx = 0; mCarry = 1'b0;
    end else begin
      mCarry = 1'b0;
      if (clr) begin
        mCount = 0;
        mTick  = 0;
      end else if (run) begin
        if (mTick == TICK - 1) begin
          mTick = 0;
          mCarry = (mCount == 9999);
          mCount = (mCount + 1) % 10000;
        end else begin
          mTick = mTick + 1;
        end
      end
      mScan = (mScan + 1) % SCAN;
      if (mScan == 0) mIdx = (mIdx + 1) % 4;
    end
  end

  function automatic int pow10(int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] toBcd(int v);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [3:0] expDigit(int v, int idx, bit blank);
    if (blank && idx > 0 && v < pow10(idx)) return 4'hF;
    return 4'((v / pow10(idx)) % 10);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [3:0] eSel;
    eSel = ~(4'b0001 << mIdx);
    check("cyc_countB", 32'(countB), 32'(toBcd(mCount)));
    check("cyc_countR", 32'(countR), 32'(toBcd(mCount)));
    check("cyc_selB",   32'(selB),   32'(eSel));
    check("cyc_selR",   32'(selR),   32'(eSel));
    check("cyc_bcdB",   32'(bcdB),   32'(expDigit(mCount, mIdx, 1'b1)));
    check("cyc_bcdR",   32'(bcdR),   32'(expDigit(mCount, mIdx, 1'b0)));
    check("cyc_carryB", 32'(carryB), 32'(mCarry));
    check("cyc_carryR", 32'(carryR), 32'(mCarry));
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkResetVals(string tag);
    check({tag, "_count"}, 32'(countB), 32'h0000);
    check({tag, "_sel"},   32'(selB),   32'hE);
    check({tag, "_bcd"},   32'(bcdB),   32'h0);
    check({tag, "_carry"}, 32'(carryB), 32'h0);
    check({tag, "_countR"}, 32'(countR), 32'h0000);
  endtask

  task automatic clearNow();
    clr = 1'b1; run = 1'b0;
    step(1);
    clr = 1'b0;
  endtask

  logic [3:0] blankTab [4];
  logic [3:0] rawTab   [4];
  logic [3:0] selTab   [4];

  initial begin
    blankTab = '{4'h2, 4'h4, 4'hF, 4'hF};
    rawTab   = '{4'h2, 4'h4, 4'h0, 4'h0};
    selTab   = '{4'hE, 4'hD, 4'hB, 4'h7};

    #1;
    checkResetVals("rst_init");
    step(1);
    rst = 1'b0;
    step(20);
    check("idle_count", 32'(countB), 32'h0000);

    run = 1'b1;
    step(36);
    check("inc_36", 32'(countB), 32'h0009);
    step(4);
    check("inc_40", 32'(countB), 32'h0010);
    run = 1'b0;
    step(50);
    check("hold_50", 32'(countB), 32'h0010);
    run = 1'b1;
    step(4);
    check("resume_11", 32'(countB), 32'h0011);
    step(2);
    run = 1'b0;
    step(10);
    run = 1'b1;
    step(2);
    check("resume_mid", 32'(countB), 32'h0012);

    clearNow();
    run = 1'b1;
    step(168);
    run = 1'b0;
    check("scan_count", 32'(countB), 32'h0042);
    begin
      int guard = 0;
      while (!(mIdx == 0 && mScan == 0) && guard < 20) begin
        step(1);
        guard++;
      end
      check("scan_sync", 32'(guard < 20), 32'h1);
    end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SCAN; c++) begin
        check("scan_sel",   32'(selB), 32'(selTab[d]));
        check("scan_blank", 32'(bcdB), 32'(blankTab[d]));
        check("scan_raw",   32'(bcdR), 32'(rawTab[d]));
        step(1);
      end
    end

    clearNow();
    run = 1'b1;
    step(123 * TICK);
    check("clr_pre", 32'(countB), 32'h0123);
    step(TICK - 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_count", 32'(countB), 32'h0000);
    check("clr_carry", 32'(carryB), 32'h0);
    step(TICK - 1);
    check("clr_not_yet", 32'(countB), 32'h0000);
    step(1);
    check("clr_next", 32'(countB), 32'h0001);

    clearNow();
    run = 1'b1;
    step(9999 * TICK);
    check("wrap_pre", 32'(countB), 32'h9999);
    check("wrap_pre_carry", 32'(carryB), 32'h0);
    step(TICK);
    check("wrap_count", 32'(countB), 32'h0000);
    check("wrap_carry_hi", 32'(carryB), 32'h1);
    step(1);
    check("wrap_carry_lo", 32'(carryB), 32'h0);

    clearNow();
    run = 1'b1;
    step(57 * TICK + 2);
    check("arst_pre", 32'(countB), 32'h0057);
    #1;
    rst = 1'b1;
    #1;
    checkResetVals("arst");
    run = 1'b0;
    step(3);
    checkResetVals("arst_hold");
    rst = 1'b0;
    step(5);
    check("arst_after", 32'(countB), 32'h0000);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
